// File: rtl/morse_pkg.sv
// Shared constants and types for the Morse letter decode path.
package morse_pkg;

  localparam logic [1:0] GAP  = 2'b00;
  localparam logic [1:0] DOT  = 2'b01;
  localparam logic [1:0] DASH = 2'b10;
  localparam logic [1:0] STOP = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DECODE,
    HOLD
  } state_t;

  localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;
  localparam logic [7:0] ASCII_SPACE   = 8'h20;

  localparam int unsigned CHAR_W               = 8;
  localparam int unsigned LEN_W                = 3;
  localparam int unsigned IDLE_CNT_W           = 9;
  localparam int unsigned DEF_MAX_SYMS         = 5;
  localparam int unsigned DEF_LETTER_GAP_TICKS = 150;
  localparam int unsigned DEF_WORD_GAP_TICKS   = 350;

endpackage

// File: rtl/morse_lut.sv
// Combinational {length, code} to ASCII table; DOT=0, DASH=1, first symbol in the MSB.
module morse_lut
  import morse_pkg::*;
#(
  parameter int unsigned CODE_W = DEF_MAX_SYMS
) (
  input  logic [LEN_W-1:0]  len,
  input  logic [CODE_W-1:0] code,
  output logic [CHAR_W-1:0] ascii_c
);

  logic [4:0] code5;

  assign code5 = 5'(code);

  always_comb begin
    ascii_c = ASCII_UNKNOWN;
    case ({len, code5})
      {3'd2, 5'b00001}: ascii_c = 8'h41; // A
      {3'd4, 5'b01000}: ascii_c = 8'h42; // B
      {3'd4, 5'b01010}: ascii_c = 8'h43; // C
      {3'd3, 5'b00100}: ascii_c = 8'h44; // D
      {3'd1, 5'b00000}: ascii_c = 8'h45; // E
      {3'd4, 5'b00010}: ascii_c = 8'h46; // F
      {3'd3, 5'b00110}: ascii_c = 8'h47; // G
      {3'd4, 5'b00000}: ascii_c = 8'h48; // H
      {3'd2, 5'b00000}: ascii_c = 8'h49; // I
      {3'd4, 5'b00111}: ascii_c = 8'h4A; // J
      {3'd3, 5'b00101}: ascii_c = 8'h4B; // K
      {3'd4, 5'b00100}: ascii_c = 8'h4C; // L
      {3'd2, 5'b00011}: ascii_c = 8'h4D; // M
      {3'd2, 5'b00010}: ascii_c = 8'h4E; // N
      {3'd3, 5'b00111}: ascii_c = 8'h4F; // O
      {3'd4, 5'b00110}: ascii_c = 8'h50; // P
      {3'd4, 5'b01101}: ascii_c = 8'h51; // Q
      {3'd3, 5'b00010}: ascii_c = 8'h52; // R
      {3'd3, 5'b00000}: ascii_c = 8'h53; // S
      {3'd1, 5'b00001}: ascii_c = 8'h54; // T
      {3'd3, 5'b00001}: ascii_c = 8'h55; // U
      {3'd4, 5'b00001}: ascii_c = 8'h56; // V
      {3'd3, 5'b00011}: ascii_c = 8'h57; // W
      {3'd4, 5'b01001}: ascii_c = 8'h58; // X
      {3'd4, 5'b01011}: ascii_c = 8'h59; // Y
      {3'd4, 5'b01100}: ascii_c = 8'h5A; // Z
      {3'd5, 5'b11111}: ascii_c = 8'h30; // 0
      {3'd5, 5'b01111}: ascii_c = 8'h31; // 1
      {3'd5, 5'b00111}: ascii_c = 8'h32; // 2
      {3'd5, 5'b00011}: ascii_c = 8'h33; // 3
      {3'd5, 5'b00001}: ascii_c = 8'h34; // 4
      {3'd5, 5'b00000}: ascii_c = 8'h35; // 5
      {3'd5, 5'b10000}: ascii_c = 8'h36; // 6
      {3'd5, 5'b11000}: ascii_c = 8'h37; // 7
      {3'd5, 5'b11100}: ascii_c = 8'h38; // 8
      {3'd5, 5'b11110}: ascii_c = 8'h39; // 9
      default:          ascii_c = ASCII_UNKNOWN;
    endcase
  end

endmodule

// File: rtl/morse_letter_sequencer.sv
// Collects DOT/DASH symbols into a letter, decodes it and holds the ASCII result for a valid/ready sink.
// Optional word-space emission is enabled with MORSE_WORD_SPACE_EN.
module morse_letter_sequencer
  import morse_pkg::*;
#(
  parameter int unsigned MAX_SYMS         = DEF_MAX_SYMS,
  parameter int unsigned LETTER_GAP_TICKS = DEF_LETTER_GAP_TICKS
`ifdef MORSE_WORD_SPACE_EN
  ,
  parameter int unsigned WORD_GAP_TICKS   = DEF_WORD_GAP_TICKS
`endif
) (
  input  logic              clock100Hz,
  input  logic              clear,
  input  logic [1:0]        sym_type,
  output logic [CHAR_W-1:0] char_data,
  output logic              char_valid,
  input  logic              char_ready,
  output logic [LEN_W-1:0]  sym_count,
  output logic              overflow
);

  state_t                  state_q, state_d;
  logic [MAX_SYMS-1:0]     code_q, code_d;
  logic [LEN_W-1:0]        count_d;
  logic                    bad_q, bad_d;
  logic [IDLE_CNT_W-1:0]   idle_q, idle_d, idle_inc;
  logic [CHAR_W-1:0]       data_d, lut_char;
  logic                    valid_d, ovf_d;
  logic                    is_sym, take;
`ifdef MORSE_WORD_SPACE_EN
  logic                    armed_q, armed_d;
`endif

  assign is_sym   = (sym_type == DOT) || (sym_type == DASH);
  assign idle_inc = (idle_q == '1) ? idle_q : idle_q + IDLE_CNT_W'(1);

  morse_lut #(
    .CODE_W (MAX_SYMS)
  ) u_lut (
    .len     (sym_count),
    .code    (code_q),
    .ascii_c (lut_char)
  );

  always_ff @(posedge clock100Hz or posedge clear) begin
    if (clear) begin
      state_q    <= IDLE;
      code_q     <= '0;
      sym_count  <= '0;
      bad_q      <= 1'b0;
      idle_q     <= '0;
      char_data  <= '0;
      char_valid <= 1'b0;
      overflow   <= 1'b0;
`ifdef MORSE_WORD_SPACE_EN
      armed_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      sym_count  <= count_d;
      bad_q      <= bad_d;
      idle_q     <= idle_d;
      char_data  <= data_d;
      char_valid <= valid_d;
      overflow   <= ovf_d;
`ifdef MORSE_WORD_SPACE_EN
      armed_q    <= armed_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    count_d = sym_count;
    bad_d   = bad_q;
    idle_d  = idle_q;
    data_d  = char_data;
    valid_d = char_valid;
    ovf_d   = overflow;
    take    = 1'b0;
`ifdef MORSE_WORD_SPACE_EN
    armed_d = armed_q;
`endif
    case (state_q)
      IDLE: begin
        if (is_sym) begin
          take    = 1'b1;
          idle_d  = '0;
          state_d = COLLECT;
        end
`ifdef MORSE_WORD_SPACE_EN
        // Armed word gap: explicit GAP or a full silent interval emits one space.
        else if (armed_q && ((sym_type == GAP) ||
                 (idle_q == IDLE_CNT_W'(WORD_GAP_TICKS - 1)))) begin
          data_d  = ASCII_SPACE;
          valid_d = 1'b1;
          armed_d = 1'b0;
          state_d = HOLD;
        end else if (armed_q) begin
          idle_d = idle_inc;
        end
`endif
      end
      COLLECT: begin
        if (is_sym) begin
          take   = 1'b1;
          idle_d = '0;
        end else if (sym_type == GAP) begin
          state_d = DECODE;
        end else if (idle_q == IDLE_CNT_W'(LETTER_GAP_TICKS - 1)) begin
          state_d = DECODE;
        end else begin
          idle_d = idle_inc;
        end
      end
      DECODE: begin
        data_d  = bad_q ? ASCII_UNKNOWN : lut_char;
        valid_d = 1'b1;
        code_d  = '0;
        count_d = '0;
        bad_d   = 1'b0;
        state_d = HOLD;
`ifdef MORSE_WORD_SPACE_EN
        armed_d = 1'b1;
`endif
      end
      HOLD: begin
        // Symbols cannot be buffered while a character is pending.
        if (is_sym) ovf_d = 1'b1;
        if (char_ready) begin
          valid_d = 1'b0;
          idle_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      if (sym_count == LEN_W'(MAX_SYMS)) begin
        ovf_d = 1'b1;
        bad_d = 1'b1;
      end else begin
        code_d  = {code_q[MAX_SYMS-2:0], sym_type == DASH};
        count_d = sym_count + LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_morse_letter_sequencer.sv
// Scoreboard bench: stimulus queues expected characters, a monitor checks every completed handshake.
module tb_morse_letter_sequencer;
  import morse_pkg::*;

  logic       clock100Hz = 1'b0;
  logic       clear      = 1'b0;
  logic [1:0] sym_type   = STOP;
  logic       char_ready = 1'b1;
  logic [7:0] char_data;
  logic       char_valid;
  logic [2:0] sym_count;
  logic       overflow;

  int unsigned checks   = 0;
  int unsigned passes   = 0;
  int unsigned rx_count = 0;
  int unsigned rx_base  = 0;
  logic [7:0]  exp_q[$];

  always #5 clock100Hz = ~clock100Hz;

  morse_letter_sequencer dut (
    .clock100Hz (clock100Hz),
    .clear      (clear),
    .sym_type   (sym_type),
    .char_data  (char_data),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .sym_count  (sym_count),
    .overflow   (overflow)
  );

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic step(input logic [1:0] s);
    sym_type = s;
    @(posedge clock100Hz);
    #1;
    sym_type = STOP;
  endtask

  // Transfer completes at the next rising edge; sample on the falling edge.
  always @(negedge clock100Hz) begin
    if (!clear && char_valid && char_ready) begin
      rx_count++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_char: got 0x%0h, expected no character", char_data);
      end else begin
        check("scoreboard_char", char_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    #1 clear = 1'b1;
    #11;
    check("reset_char_data", char_data, 0);
    check("reset_char_valid", char_valid, 0);
    check("reset_sym_count", sym_count, 0);
    check("reset_overflow", overflow, 0);
    @(posedge clock100Hz);
    #1 clear = 1'b0;

    // DOT DASH GAP -> 'A', two cycles after GAP
    step(DOT);  check("a_count1", sym_count, 1);
    step(DASH); check("a_count2", sym_count, 2);
    exp_q.push_back(8'h41);
    step(GAP);  check("a_valid_not_yet", char_valid, 0);
    step(STOP);
    check("a_valid", char_valid, 1);
    check("a_count0", sym_count, 0);
    check("a_data", char_data, 8'h41);
    step(STOP); check("a_valid_drop", char_valid, 0);

    // Five DASH then timeout: commit on tick 150 exactly
    repeat (5) step(DASH);
    repeat (149) step(STOP);
    check("zero_tick149_count", sym_count, 5);
    step(STOP);
    check("zero_tick150_decode", {char_valid, sym_count}, {1'b0, 3'd5});
    exp_q.push_back(8'h30);
    step(STOP);
    check("zero_valid", char_valid, 1);
    check("zero_data", char_data, 8'h30);
    step(STOP);

    // Six DOTs -> overflow and '?'
    repeat (6) step(DOT);
    check("ovf_set", overflow, 1);
    check("ovf_count_sat", sym_count, 5);
    exp_q.push_back(8'h3F);
    step(GAP);
    step(STOP);
    check("ovf_data", char_data, 8'h3F);
    repeat (5) step(STOP);
    check("ovf_sticky", overflow, 1);

    // Asynchronous clear between edges
    #2 clear = 1'b1;
    #1;
    check("clear_overflow", overflow, 0);
    check("clear_data", char_data, 0);
    @(posedge clock100Hz);
    #1 clear = 1'b0;

    // 'E' held with ready low while DOTs arrive
    char_ready = 1'b0;
    step(DOT);
    exp_q.push_back(8'h45);
    step(GAP);
    step(STOP);
    check("hold_valid", char_valid, 1);
    for (int i = 0; i < 20; i++) begin
      step((i < 3) ? DOT : STOP);
      check("hold_stable", {char_valid, char_data}, {1'b1, 8'h45});
    end
    check("hold_overflow", overflow, 1);
    char_ready = 1'b1;
    step(STOP);
    check("hold_released", char_valid, 0);
    step(DASH);
    exp_q.push_back(8'h54);
    step(GAP);
    step(STOP);
    check("after_hold_T", char_data, 8'h54);
    step(STOP);

    // Symbol in the handshake cycle is dropped
    char_ready = 1'b0;
    step(DOT);
    exp_q.push_back(8'h45);
    step(GAP);
    step(STOP);
    char_ready = 1'b1;
    step(DASH);
    check("simul_valid_drop", char_valid, 0);
    check("simul_count", sym_count, 0);
    step(DOT);
    step(DASH);
    exp_q.push_back(8'h41);
    step(GAP);
    step(STOP);
    check("simul_next_A", char_data, 8'h41);
    step(STOP);

    // Clear mid-letter
    step(DASH);
    step(DOT);
    check("mid_count", sym_count, 2);
    #2 clear = 1'b1;
    #1;
    check("mid_clear_all", {char_valid, overflow, sym_count, char_data}, 0);
    @(posedge clock100Hz);
    #1 clear = 1'b0;
    step(DOT);
    exp_q.push_back(8'h45);
    step(GAP);
    step(STOP);
    check("post_clear_E", char_data, 8'h45);
    step(STOP);

`ifdef MORSE_WORD_SPACE_EN
    // One space after 350 idle ticks, none afterwards
    rx_base = rx_count;
    repeat (349) step(STOP);
    check("space_not_early", char_valid, 0);
    exp_q.push_back(ASCII_SPACE);
    step(STOP);
    check("space_valid", {char_valid, char_data}, {1'b1, ASCII_SPACE});
    repeat (1000) step(STOP);
    check("space_once", rx_count - rx_base, 1);
`else
    rx_base = rx_count;
    repeat (400) step(STOP);
    check("no_space", rx_count - rx_base, 0);
`endif

    check("queue_drained", exp_q.size(), 0);
`ifdef MORSE_WORD_SPACE_EN
    check("rx_total", rx_count, 9);
`else
    check("rx_total", rx_count, 8);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
